dma_dsc_issuer: RTL and testbench
=================================

# dma_dsc_issuer

Descriptor-bypass initiator for one XDMA channel direction (instantiate once for C2H, once for H2C). It accepts transfer commands (host address, byte length) from user logic and splits each into MAX_CHUNK-aligned descriptors. It drives them onto the DMA driver's `*_dsc_byp_*` inputs under the ready/load handshake. It retires descriptors by snooping `last` on the matching data stream and pulses `cmd_done` when every descriptor of a command has retired.

## Interface
Parameters:
- MAX_CHUNK, 4096: maximum descriptor bytes; power of two, 64..2^27.
- MAX_OUTSTANDING, 8: maximum issued-but-unretired descriptors; power of two, at most 256.

Ports:
- pcie_clk  in  1  clock; all logic on the rising edge.
- pcie_aresetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  64  host byte address.
- cmd_len  in  32  byte length; only [27:0] is used, and [31:28] nonzero sets err.
- dsc_byp_ready  in  1  DMA can take a descriptor.
- dsc_byp_load  out  1  descriptor presented this cycle.
- dsc_byp_addr  out  64  descriptor host address.
- dsc_byp_len  out  32  descriptor bytes; [31:28] are always 0.
- strm_valid, strm_ready, strm_last  in  1 each  snoop of the channel data stream; passive.
- cmd_done  out  1  one-cycle pulse when a command has fully retired.
- busy  out  1  high whenever state is not IDLE.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  live descriptor count.
- err  out  1  sticky error; cleared only by reset.

## Operation
- States:
  - IDLE: cmd_ready=1. On a cmd_valid handshake, latch addr into cur_addr and len[27:0] into remaining. Go to ISSUE, or to DRAIN when the length is 0.
  - ISSUE: present a chunk. Go to DRAIN on the load that makes remaining 0.
  - DRAIN: wait for outstanding==0, then pulse cmd_done and go to IDLE.
- Chunk length: chunk = min(remaining, MAX_CHUNK − (cur_addr mod MAX_CHUNK)).
  - A descriptor never crosses a MAX_CHUNK boundary.
  - The first chunk may be short; middle chunks are full.
- Load rule: dsc_byp_load = (state==ISSUE) && dsc_byp_ready && (outstanding < MAX_OUTSTANDING).
  - In ISSUE, dsc_byp_addr=cur_addr and dsc_byp_len=chunk.
  - On load: cur_addr += chunk; remaining −= chunk; outstanding increments.
- Retire: each strm_valid && strm_ready && strm_last handshake decrements outstanding.
  - Simultaneous load and retire leaves outstanding unchanged.
- Error conditions, each of which sets err:
  - A retire while outstanding==0 is ignored.
  - A command with cmd_len[31:28]≠0 is executed using [27:0].
- Address wrap past 2^64 is not checked; cur_addr wraps modulo 2^64.

## Timing
- Reset values:
  - Asserting reset in any state aborts the command immediately; no cmd_done is generated.
  - Outputs: cmd_ready=0 during reset and 1 in the first cycle after; dsc_byp_load=0; dsc_byp_addr=0; dsc_byp_len=0; cmd_done=0; busy=0; outstanding=0; err=0.
  - Internal: state=IDLE.
- Command handshake in cycle N: ISSUE in N+1, earliest load in N+1.
- Loads are back-to-back, one per cycle, while ready and not full.
- dsc_byp_addr and dsc_byp_len are driven from registers; in ISSUE they are stable while dsc_byp_ready=0.
- cmd_done: single pulse in the cycle DRAIN observes outstanding==0; IDLE (cmd_ready=1) follows in the next cycle.
- Zero-length command handshaked in cycle N: cmd_done pulses in N+1; no descriptors are issued.

## Configuration
- DSC_ISSUER_STATS_EN defined:
  - Adds outputs stat_dsc_cnt[31:0] (descriptors loaded) and stat_byte_cnt[63:0] (sum of dsc_byp_len over loads).
  - Both reset to 0 and wrap modulo 2^width.
- DSC_ISSUER_STATS_EN undefined: these ports and counters do not exist.

## Structure
- Shared package dma_pkg holds:
  - the issuer_state_t enum (IDLE, ISSUE, DRAIN);
  - DSC_LEN_W=28;
  - the dma_cmd_t struct {addr[63:0], len[31:0]}.
- Sub-module dsc_chunk_calc: combinational chunk length from cur_addr, remaining and MAX_CHUNK, so it can be unit-tested.
- Everything else stays in dma_dsc_issuer.

## Test plan
- Aligned command, MAX_CHUNK=4096: addr=0x1000, len=12288, ready tied 1 → three loads in consecutive cycles (0x1000/4096, 0x2000/4096, 0x3000/4096). After three stream lasts, one cmd_done pulse.
- Unaligned command: addr=0x0F00, len=0x1200 → loads 0x0F00/256, 0x1000/4096, 0x2000/256.
- Backpressure: ready toggles 1,0,0,1 → addr/len held stable while low; no duplicate or dropped descriptor.
- Outstanding limit, MAX_OUTSTANDING=2, no lasts sent: len=16384 → exactly 2 loads, then stall. Each last releases one more load; cmd_done follows the 4th last.
- Zero-length command, and a last with outstanding=0 → cmd_done one cycle after the handshake; the stray last sets err, and outstanding stays 0.
- Reset mid-command: reset after 1 of 3 loads → all outputs return to reset values and there is no cmd_done; a following command addr=0, len=64 → one 0x0/64 load.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA descriptor issuer
package dma_pkg;

    // Descriptor byte count width; upper bits of command/descriptor lengths are unused.
    localparam int DSC_LEN_W = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } issuer_state_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] len;
    } dma_cmd_t;

endpackage

// File: rtl/dsc_chunk_calc.sv
// rtl/dsc_chunk_calc.sv - combinational descriptor chunk length
// Ports:
//   addr_off  - cur_addr modulo MAX_CHUNK (low log2(MAX_CHUNK) address bits)
//   remaining - bytes left in the current command
//   chunk     - min(remaining, MAX_CHUNK - addr_off); never crosses a MAX_CHUNK boundary
module dsc_chunk_calc
    import dma_pkg::*;
#(
    parameter int MAX_CHUNK = 4096
) (
    input  logic [$clog2(MAX_CHUNK)-1:0] addr_off,
    input  logic [DSC_LEN_W-1:0]         remaining,
    output logic [DSC_LEN_W-1:0]         chunk
);

    logic [DSC_LEN_W-1:0] room;

    always_comb begin
        room  = DSC_LEN_W'(MAX_CHUNK) - DSC_LEN_W'(addr_off);
        chunk = (remaining < room) ? remaining : room;
    end

endmodule

// File: rtl/dma_dsc_issuer.sv
// rtl/dma_dsc_issuer.sv - splits host transfer commands into descriptor-bypass loads
// Ports:
//   pcie_clk, pcie_aresetn        - clock, synchronous active-low reset
//   cmd_valid/cmd_ready/addr/len  - command intake (len[31:28] nonzero flags err)
//   dsc_byp_ready/load/addr/len   - descriptor bypass handshake toward the DMA engine
//   strm_valid/ready/last         - passive snoop of the data stream; last retires a descriptor
//   cmd_done                      - one-cycle pulse when a command has fully retired
//   busy, outstanding, err        - status; err is sticky until reset
//   stat_dsc_cnt, stat_byte_cnt   - load/byte counters, only with DSC_ISSUER_STATS_EN defined
module dma_dsc_issuer
    import dma_pkg::*;
#(
    parameter int MAX_CHUNK       = 4096,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               pcie_clk,
    input  logic                               pcie_aresetn,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [63:0]                        cmd_addr,
    input  logic [31:0]                        cmd_len,
    input  logic                               dsc_byp_ready,
    output logic                               dsc_byp_load,
    output logic [63:0]                        dsc_byp_addr,
    output logic [31:0]                        dsc_byp_len,
    input  logic                               strm_valid,
    input  logic                               strm_ready,
    input  logic                               strm_last,
    output logic                               cmd_done,
    output logic                               busy,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err
`ifdef DSC_ISSUER_STATS_EN
    ,
    output logic [31:0]                        stat_dsc_cnt,
    output logic [63:0]                        stat_byte_cnt
`endif
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CW = $clog2(MAX_CHUNK);

    issuer_state_t        state, state_nxt;
    dma_cmd_t             cmd_in;
    logic [63:0]          cur_addr;
    logic [DSC_LEN_W-1:0] remaining;
    logic [DSC_LEN_W-1:0] chunk;
    logic                 cmd_hs;
    logic                 load;
    logic                 retire;
    logic                 retire_ok;
    logic                 drained;

    assign cmd_in    = '{addr: cmd_addr, len: cmd_len};
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign load      = pcie_aresetn && (state == ISSUE) && dsc_byp_ready
                       && (outstanding < OW'(MAX_OUTSTANDING));
    assign retire    = strm_valid && strm_ready && strm_last;
    // A last with nothing outstanding is stray: flagged, never counted.
    assign retire_ok = retire && (outstanding != '0);
    assign drained   = (outstanding == '0);

    dsc_chunk_calc #(
        .MAX_CHUNK (MAX_CHUNK)
    ) u_chunk (
        .addr_off  (cur_addr[CW-1:0]),
        .remaining (remaining),
        .chunk     (chunk)
    );

    always_ff @(posedge pcie_clk) begin
        if (!pcie_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    state_nxt = (cmd_in.len[DSC_LEN_W-1:0] == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (load && (chunk == remaining)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced inactive while reset is asserted, even before the reset edge.
    always_comb begin
        cmd_ready    = 1'b0;
        dsc_byp_load = load;
        dsc_byp_addr = '0;
        dsc_byp_len  = '0;
        cmd_done     = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE:  cmd_ready = pcie_aresetn;
            ISSUE: begin
                dsc_byp_addr = cur_addr;
                dsc_byp_len  = 32'(chunk);
            end
            DRAIN: cmd_done = pcie_aresetn && drained;
            default: ;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (!pcie_aresetn) begin
            cur_addr    <= '0;
            remaining   <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (cmd_hs) begin
                cur_addr  <= cmd_in.addr;
                remaining <= cmd_in.len[DSC_LEN_W-1:0];
            end else if (load) begin
                cur_addr  <= cur_addr + 64'(chunk);
                remaining <= remaining - chunk;
            end

            case ({load, retire_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            if ((cmd_hs && (cmd_in.len[31:DSC_LEN_W] != '0)) || (retire && drained)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef DSC_ISSUER_STATS_EN
    always_ff @(posedge pcie_clk) begin
        if (!pcie_aresetn) begin
            stat_dsc_cnt  <= '0;
            stat_byte_cnt <= '0;
        end else if (load) begin
            stat_dsc_cnt  <= stat_dsc_cnt + 32'd1;
            stat_byte_cnt <= stat_byte_cnt + 64'(chunk);
        end
    end
`endif

endmodule

// File: tb/tb_dma_dsc_issuer.sv
// tb/tb_dma_dsc_issuer.sv - self-checking bench for dma_dsc_issuer
module tb_dma_dsc_issuer;

    logic        pcie_clk = 1'b0;
    logic        pcie_aresetn;
    logic        cmd_valid, cmd_valid2;
    logic [63:0] cmd_addr;
    logic [31:0] cmd_len;
    logic        dsc_byp_ready;
    logic        strm_valid, strm_ready, strm_last, strm_last2;

    logic        cmd_ready, dsc_byp_load, cmd_done, busy, err;
    logic [63:0] dsc_byp_addr;
    logic [31:0] dsc_byp_len;
    logic [3:0]  outstanding;

    logic        cmd_ready2, dsc_byp_load2, cmd_done2, busy2, err2;
    logic [63:0] dsc_byp_addr2;
    logic [31:0] dsc_byp_len2;
    logic [1:0]  outstanding2;

`ifdef DSC_ISSUER_STATS_EN
    logic [31:0] stat_dsc_cnt, stat_dsc_cnt2;
    logic [63:0] stat_byte_cnt, stat_byte_cnt2;
`endif

    always #5 pcie_clk = ~pcie_clk;

    dma_dsc_issuer #(.MAX_CHUNK(4096), .MAX_OUTSTANDING(8)) dut (
        .pcie_clk      (pcie_clk),
        .pcie_aresetn  (pcie_aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .dsc_byp_ready (dsc_byp_ready),
        .dsc_byp_load  (dsc_byp_load),
        .dsc_byp_addr  (dsc_byp_addr),
        .dsc_byp_len   (dsc_byp_len),
        .strm_valid    (strm_valid),
        .strm_ready    (strm_ready),
        .strm_last     (strm_last),
        .cmd_done      (cmd_done),
        .busy          (busy),
        .outstanding   (outstanding),
        .err           (err)
`ifdef DSC_ISSUER_STATS_EN
        ,
        .stat_dsc_cnt  (stat_dsc_cnt),
        .stat_byte_cnt (stat_byte_cnt)
`endif
    );

    dma_dsc_issuer #(.MAX_CHUNK(4096), .MAX_OUTSTANDING(2)) dut2 (
        .pcie_clk      (pcie_clk),
        .pcie_aresetn  (pcie_aresetn),
        .cmd_valid     (cmd_valid2),
        .cmd_ready     (cmd_ready2),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .dsc_byp_ready (dsc_byp_ready),
        .dsc_byp_load  (dsc_byp_load2),
        .dsc_byp_addr  (dsc_byp_addr2),
        .dsc_byp_len   (dsc_byp_len2),
        .strm_valid    (strm_valid),
        .strm_ready    (strm_ready),
        .strm_last     (strm_last2),
        .cmd_done      (cmd_done2),
        .busy          (busy2),
        .outstanding   (outstanding2),
        .err           (err2)
`ifdef DSC_ISSUER_STATS_EN
        ,
        .stat_dsc_cnt  (stat_dsc_cnt2),
        .stat_byte_cnt (stat_byte_cnt2)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        int          n;
        logic [63:0] ea [3];
        logic [31:0] el [3];
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    vec_t        vecs [4];
    logic [63:0] ld_addr [8];
    logic [31:0] ld_len  [8];
    int          ld_cyc  [8];
    int          ld_n;
    int          dones;

    function automatic vec_t mk(logic [63:0] a, logic [31:0] l, int n,
                                logic [63:0] a0, logic [31:0] l0,
                                logic [63:0] a1, logic [31:0] l1,
                                logic [63:0] a2, logic [31:0] l2);
        vec_t v;
        v.addr = a;  v.len = l;  v.n = n;
        v.ea[0] = a0; v.el[0] = l0;
        v.ea[1] = a1; v.el[1] = l1;
        v.ea[2] = a2; v.el[2] = l2;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic send_cmd(logic [63:0] a, logic [31:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_at_handshake", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Records every load of dut over ncyc cycles, starting in the cycle after the handshake.
    task automatic run_loads(int ncyc);
        ld_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (dsc_byp_load) begin
                if (ld_n < 8) begin
                    ld_addr[ld_n] = dsc_byp_addr;
                    ld_len[ld_n]  = dsc_byp_len;
                    ld_cyc[ld_n]  = c;
                end
                ld_n++;
            end
            tick();
        end
    endtask

    // Pulses n lasts to dut, then watches tail cycles; counts cmd_done pulses.
    task automatic send_lasts(int n, int tail);
        dones = 0;
        for (int i = 0; i < n + tail; i++) begin
            strm_valid = (i < n);
            strm_ready = (i < n);
            strm_last  = (i < n);
            #1;
            if (cmd_done) dones++;
            tick();
        end
        strm_valid = 1'b0;
        strm_ready = 1'b0;
        strm_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp [6];
        int exp_ld [4];
        int exp_dn [4];
        int n2, d2;
        logic [63:0] last_addr2;

        vecs[0] = mk(64'h1000, 32'd12288, 3, 64'h1000, 32'd4096, 64'h2000, 32'd4096, 64'h3000, 32'd4096);
        vecs[1] = mk(64'h0F00, 32'h1200,  3, 64'h0F00, 32'h100,  64'h1000, 32'h1000, 64'h2000, 32'h100);
        vecs[2] = mk(64'h0040, 32'd64,    1, 64'h0040, 32'd64,   64'h0,    32'd0,    64'h0,    32'd0);
        vecs[3] = mk(64'h0FC0, 32'd128,   2, 64'h0FC0, 32'd64,   64'h1000, 32'd64,   64'h0,    32'd0);
        bp = '{1, 0, 0, 1, 1, 1};
        exp_ld = '{1, 1, 0, 0};
        exp_dn = '{0, 0, 0, 1};

        pcie_aresetn = 1'b0;
        cmd_valid = 1'b0; cmd_valid2 = 1'b0;
        cmd_addr = '0; cmd_len = '0;
        dsc_byp_ready = 1'b1;
        strm_valid = 1'b0; strm_ready = 1'b0; strm_last = 1'b0; strm_last2 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_load", 64'(dsc_byp_load), 64'd0);
        chk("rst_addr", dsc_byp_addr, 64'd0);
        chk("rst_len", 64'(dsc_byp_len), 64'd0);
        chk("rst_done", 64'(cmd_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        pcie_aresetn = 1'b1;
        #1;
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
        tick();

        // Table of commands with ready tied high
        for (int v = 0; v < 4; v++) begin
            send_cmd(vecs[v].addr, vecs[v].len);
            run_loads(8);
            chk($sformatf("v%0d_nloads", v), 64'(ld_n), 64'(vecs[v].n));
            for (int i = 0; i < vecs[v].n && i < ld_n; i++) begin
                chk($sformatf("v%0d_addr%0d", v, i), ld_addr[i], vecs[v].ea[i]);
                chk($sformatf("v%0d_len%0d", v, i), 64'(ld_len[i]), 64'(vecs[v].el[i]));
                chk($sformatf("v%0d_cyc%0d", v, i), 64'(ld_cyc[i]), 64'(i));
            end
            chk($sformatf("v%0d_outstanding", v), 64'(outstanding), 64'(vecs[v].n));
            send_lasts(vecs[v].n, 4);
            chk($sformatf("v%0d_done_pulses", v), 64'(dones), 64'd1);
            chk($sformatf("v%0d_idle", v), 64'(cmd_ready), 64'd1);
            chk($sformatf("v%0d_err", v), 64'(err), 64'd0);
        end

        // Backpressure: ready 1,0,0,1 then high
        send_cmd(64'h0, 32'd8192);
        ld_n = 0;
        for (int c = 0; c < 6; c++) begin
            dsc_byp_ready = bp[c][0];
            #1;
            if (c == 1 || c == 2) begin
                chk($sformatf("bp_hold_addr%0d", c), dsc_byp_addr, 64'h1000);
                chk($sformatf("bp_hold_len%0d", c), 64'(dsc_byp_len), 64'd4096);
                chk($sformatf("bp_noload%0d", c), 64'(dsc_byp_load), 64'd0);
            end
            if (dsc_byp_load) begin
                if (ld_n < 8) ld_addr[ld_n] = dsc_byp_addr;
                ld_n++;
            end
            tick();
        end
        dsc_byp_ready = 1'b1;
        chk("bp_nloads", 64'(ld_n), 64'd2);
        chk("bp_addr0", ld_addr[0], 64'h0);
        chk("bp_addr1", ld_addr[1], 64'h1000);
        send_lasts(2, 4);
        chk("bp_done_pulses", 64'(dones), 64'd1);

        // Zero-length command, then a stray last
        send_cmd(64'h8000, 32'd0);
        #1;
        chk("zl_done", 64'(cmd_done), 64'd1);
        chk("zl_noload", 64'(dsc_byp_load), 64'd0);
        tick();
        chk("zl_done_once", 64'(cmd_done), 64'd0);
        chk("zl_idle", 64'(cmd_ready), 64'd1);
        chk("stray_err_before", 64'(err), 64'd0);
        send_lasts(1, 1);
        chk("stray_err", 64'(err), 64'd1);
        chk("stray_outstanding", 64'(outstanding), 64'd0);

        // Outstanding limit of 2 on the second instance
        cmd_addr = 64'h0; cmd_len = 32'd16384; cmd_valid2 = 1'b1;
        #1;
        chk("lim_cmd_ready", 64'(cmd_ready2), 64'd1);
        tick();
        cmd_valid2 = 1'b0;
        n2 = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (dsc_byp_load2) n2++;
            tick();
        end
        chk("lim_initial_loads", 64'(n2), 64'd2);
        chk("lim_outstanding", 64'(outstanding2), 64'd2);
        last_addr2 = '0;
        for (int k = 0; k < 4; k++) begin
            n2 = 0; d2 = 0;
            for (int c = 0; c < 4; c++) begin
                strm_valid = (c == 0); strm_ready = (c == 0); strm_last2 = (c == 0);
                #1;
                if (dsc_byp_load2) begin
                    n2++;
                    last_addr2 = dsc_byp_addr2;
                end
                if (cmd_done2) d2++;
                tick();
            end
            strm_valid = 1'b0; strm_ready = 1'b0; strm_last2 = 1'b0;
            chk($sformatf("lim_loads_after_last%0d", k), 64'(n2), 64'(exp_ld[k]));
            chk($sformatf("lim_done_after_last%0d", k), 64'(d2), 64'(exp_dn[k]));
        end
        chk("lim_last_addr", last_addr2, 64'h3000);

        // Reset after 1 of 3 loads
        send_cmd(64'h1000, 32'd12288);
        #1;
        chk("mid_first_load", 64'(dsc_byp_load), 64'd1);
        tick();
        dsc_byp_ready = 1'b0;
        pcie_aresetn = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_load", 64'(dsc_byp_load), 64'd0);
        tick();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_addr", dsc_byp_addr, 64'd0);
        chk("mid_rst_len", 64'(dsc_byp_len), 64'd0);
        chk("mid_rst_done", 64'(cmd_done), 64'd0);
        pcie_aresetn = 1'b1;
        dsc_byp_ready = 1'b1;
        #1;
        chk("mid_post_cmd_ready", 64'(cmd_ready), 64'd1);
        send_lasts(0, 4);
        chk("mid_no_done", 64'(dones), 64'd0);
        send_cmd(64'h0, 32'd64);
        run_loads(4);
        chk("post_nloads", 64'(ld_n), 64'd1);
        chk("post_addr", ld_addr[0], 64'h0);
        chk("post_len", 64'(ld_len[0]), 64'd64);
        send_lasts(1, 3);
        chk("post_done", 64'(dones), 64'd1);

        // Length with [31:28] set runs on [27:0] and flags err
        send_cmd(64'h5000, 32'h1000_0040);
        run_loads(4);
        chk("hibits_nloads", 64'(ld_n), 64'd1);
        chk("hibits_addr", ld_addr[0], 64'h5000);
        chk("hibits_len", 64'(ld_len[0]), 64'h40);
        chk("hibits_err", 64'(err), 64'd1);
        send_lasts(1, 3);
        chk("hibits_done", 64'(dones), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
